ysyx_23060240_axi_sram: RTL and testbench
=========================================

YSYX_23060240_AXI_SRAM -- requirements
Module: ysyx_23060240_axi_sram

Interface
REQ-001 The block SHALL be the single-beat AXI slave memory driven by the instruction-fetch master's read and write channels, with these parameters:
REQ-002 DEPTH_LOG2, 12, log2 of memory depth in 32-bit words.
REQ-003 RD_LAT, 3, cycles from AR handshake to rvalid assertion; legal range 1..15.
REQ-004 BASE, 32'h80000000, byte address of word 0.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high. Ports are:
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 araddr  in  32  read byte address.
REQ-009 arvalid  in  1  read address valid.
REQ-010 arready  out  1  read address ready.
REQ-011 rdata  out  32  read data.
REQ-012 rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-013 rvalid  out  1  read data valid.
REQ-014 rready  in  1  read data ready.
REQ-015 awaddr  in  32  write byte address.
REQ-016 awvalid  in  1  write address valid.
REQ-017 awready  out  1  write address ready.
REQ-018 wdata  in  32  write data.
REQ-019 wstrb  in  4  byte write enables; bit i enables wdata[8i+7:8i].
REQ-020 wvalid  in  1  write data valid.
REQ-021 wready  out  1  write data ready.
REQ-022 bresp  out  2  write response, same encoding as rresp.
REQ-023 bvalid  out  1  write response valid.
REQ-024 bready  in  1  write response ready.

Function
REQ-025 Word index SHALL be computed as (addr-BASE)[DEPTH_LOG2+1:2]; addr[1:0] is ignored; addr<BASE or addr>=BASE+4*2^DEPTH_LOG2 is out of range.
REQ-026 Read FSM SHALL have states R_IDLE, R_WAIT and R_RESP; arready=1 only in R_IDLE.
REQ-027 R_IDLE->R_WAIT on arvalid&&arready: the address is latched and a latency counter is loaded with RD_LAT-1.
REQ-028 In R_WAIT the counter SHALL decrement each cycle; when it reaches 0, rdata/rresp are captured and the FSM goes to R_RESP, so that an AR handshake in cycle T gives rvalid=1 in cycle T+RD_LAT.
REQ-029 In R_RESP rvalid=1, and rdata/rresp SHALL hold stable until rready; on rvalid&&rready the FSM goes to R_IDLE, with arready=1 in the next cycle.
REQ-030 An out-of-range read SHALL return rdata=0 and rresp=2'b10.
REQ-031 Write FSM SHALL have states W_IDLE, W_DATA, W_ADDR and W_RESP; W_IDLE has awready=wready=1.
REQ-032 AW and W handshakes SHALL be accepted in either order or in the same cycle: AW-only goes to W_DATA (awready=0, wready=1); W-only goes to W_ADDR (wready=0, awready=1); both in one cycle, or the second handshake, goes to W_RESP.
REQ-033 The memory write SHALL commit on the edge that enters W_RESP, honouring wstrb per byte; bvalid=1 in W_RESP, i.e. one cycle after the last of the two handshakes.
REQ-034 An out-of-range write SHALL modify nothing and give bresp=2'b10; in-range writes give 2'b00.
REQ-035 On bvalid&&bready the write FSM SHALL go to W_IDLE.
REQ-036 Read and write FSMs SHALL operate independently.
REQ-037 A read capture and a write commit to the same word on the same edge SHALL return the old data (read-before-write); a write committed on any earlier edge SHALL be visible.
REQ-038 wstrb=4'b0000 SHALL complete the handshake with bresp=2'b00 and leave memory unchanged.

Reset
REQ-039 While rst=1 at a rising edge, both FSMs SHALL go to idle: arready=awready=wready=1, rvalid=bvalid=0, rdata=0, rresp=bresp=2'b00, latency counter=0.
REQ-040 A transaction in flight when reset is asserted SHALL be abandoned with no response issued; a write not yet committed SHALL NOT modify memory.
REQ-041 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-042 Reset held 2 cycles then released -> arready=awready=wready=1, rvalid=bvalid=0, rdata=0.
REQ-043 Write 32'hDEADBEEF, wstrb 4'hF, to 32'h80000010, AW+W in cycle T -> bvalid=1 at T+1, bresp=00; then read 32'h80000010 with AR at T' -> rvalid=1 at T'+3, rdata=32'hDEADBEEF.
REQ-044 W (32'h0000CAFE, wstrb 4'b0011) two cycles before AW to 32'h80000010 -> bvalid=1 one cycle after AW; a following read returns 32'hDEADCAFE.
REQ-045 Read with rready held 0 for 5 cycles after rvalid -> rvalid and rdata stable, arready=0 throughout; arready=1 in the cycle after the handshake.
REQ-046 Read 32'h70000000 -> rresp=2'b10, rdata=0; write to 32'h70000000 -> bresp=2'b10 and memory unchanged.
REQ-047 rst asserted one cycle after an AR handshake -> rvalid stays 0 and arready=1 after reset.

Source files
------------

// File: rtl/ysyx_23060240_axi_sram_if.sv
// AXI-lite style single-beat bus between the fetch master and the SRAM.
// Read and write channels with their valid/ready handshakes.
interface ysyx_23060240_axi_sram_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready,
      output awaddr, awvalid,
      output wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready,
      input  awaddr, awvalid,
      input  wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/ysyx_23060240_axi_sram.sv
// Single-beat AXI slave SRAM with fixed read latency.
// Independent read and write FSMs; read-before-write on the same edge.
module ysyx_23060240_axi_sram #(
   parameter int          DEPTH_LOG2 = 12,
   parameter int          RD_LAT     = 3,
   parameter logic [31:0] BASE       = 32'h8000_0000
) (
   input logic                     clk,
   input logic                     rst,
   ysyx_23060240_axi_sram_if.slave bus
);

   localparam int AW = DEPTH_LOG2;

   logic [31:0] mem [0:(1<<AW)-1];

   function automatic logic in_range(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (a >= BASE) && ((off >> (AW + 2)) == 32'd0);
   endfunction

   function automatic logic [AW-1:0] widx(input logic [31:0] a);
      logic [31:0] off;
      off = (a - BASE) >> 2;
      return AW'(off);
   endfunction

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } r_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_ADDR,
      W_RESP
   } w_state_t;

   r_state_t    r_st, r_nx;
   logic [3:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_cap;
   logic [31:0] r_cap_addr;

   w_state_t    w_st, w_nx;
   logic [31:0] w_addr;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic [1:0]  w_resp;
   logic        aw_hs, w_hs;
   logic        w_commit;
   logic [31:0] c_addr;
   logic [31:0] c_data;
   logic [3:0]  c_strb;

   // read FSM next state; capture happens on the edge that enters R_RESP
   always_comb begin
      r_nx        = r_st;
      r_cap       = 1'b0;
      bus.arready = 1'b0;
      unique case (r_st)
         R_IDLE: begin
            bus.arready = 1'b1;
            if (bus.arvalid) begin
               if (RD_LAT == 1) begin
                  r_nx  = R_RESP;
                  r_cap = 1'b1;
               end else begin
                  r_nx = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            if (r_cnt <= 4'd1) begin
               r_nx  = R_RESP;
               r_cap = 1'b1;
            end
         end
         R_RESP: begin
            if (bus.rready) r_nx = R_IDLE;
         end
         default: r_nx = R_IDLE;
      endcase
   end

   assign r_cap_addr = (r_st == R_IDLE) ? bus.araddr : r_addr;
   assign bus.rvalid = (r_st == R_RESP);
   assign bus.rdata  = r_data;
   assign bus.rresp  = r_resp;

   // read state register
   always_ff @(posedge clk) begin
      if (rst) r_st <= R_IDLE;
      else     r_st <= r_nx;
   end

   // read address latch, latency counter and response capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= 4'd0;
         r_addr <= 32'd0;
         r_data <= 32'd0;
         r_resp <= 2'b00;
      end else begin
         if (r_st == R_IDLE && bus.arvalid) begin
            r_addr <= bus.araddr;
            r_cnt  <= 4'(RD_LAT - 1);
         end else if (r_st == R_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (r_cap) begin
            if (in_range(r_cap_addr)) begin
               r_data <= mem[widx(r_cap_addr)];
               r_resp <= 2'b00;
            end else begin
               r_data <= 32'd0;
               r_resp <= 2'b10;
            end
         end
      end
   end

   assign bus.awready = (w_st == W_IDLE) || (w_st == W_ADDR);
   assign bus.wready  = (w_st == W_IDLE) || (w_st == W_DATA);
   assign aw_hs       = bus.awvalid && bus.awready;
   assign w_hs        = bus.wvalid && bus.wready;

   // write FSM next state; AW and W may arrive in either order
   always_comb begin
      w_nx = w_st;
      unique case (w_st)
         W_IDLE: begin
            if (aw_hs && w_hs) w_nx = W_RESP;
            else if (aw_hs)    w_nx = W_DATA;
            else if (w_hs)     w_nx = W_ADDR;
         end
         W_DATA: if (w_hs)       w_nx = W_RESP;
         W_ADDR: if (aw_hs)      w_nx = W_RESP;
         W_RESP: if (bus.bready) w_nx = W_IDLE;
         default: w_nx = W_IDLE;
      endcase
   end

   assign w_commit   = (w_st != W_RESP) && (w_nx == W_RESP);
   assign c_addr     = aw_hs ? bus.awaddr : w_addr;
   assign c_data     = w_hs ? bus.wdata : w_data;
   assign c_strb     = w_hs ? bus.wstrb : w_strb;
   assign bus.bvalid = (w_st == W_RESP);
   assign bus.bresp  = w_resp;

   // write state register
   always_ff @(posedge clk) begin
      if (rst) w_st <= W_IDLE;
      else     w_st <= w_nx;
   end

   // hold whichever half of the write arrived first, set response
   always_ff @(posedge clk) begin
      if (rst) begin
         w_addr <= 32'd0;
         w_data <= 32'd0;
         w_strb <= 4'd0;
         w_resp <= 2'b00;
      end else begin
         if (aw_hs) w_addr <= bus.awaddr;
         if (w_hs) begin
            w_data <= bus.wdata;
            w_strb <= bus.wstrb;
         end
         if (w_commit) w_resp <= in_range(c_addr) ? 2'b00 : 2'b10;
      end
   end

   // byte-masked memory write; contents survive reset
   always_ff @(posedge clk) begin
      if (!rst && w_commit && in_range(c_addr)) begin
         for (int b = 0; b < 4; b++) begin
            if (c_strb[b])
               mem[widx(c_addr)][8*b +: 8] <= c_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060240_axi_sram.sv
// Self-checking bench for the AXI SRAM: directed cases plus
// randomized traffic against a word-array reference model.
module tb_ysyx_23060240_axi_sram;

   localparam int          RD_LAT = 3;
   localparam logic [31:0] BASE   = 32'h8000_0000;
   localparam longint      WORDS  = 4096;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [31:0] mdl [int];
   logic [31:0] addrs [16];

   ysyx_23060240_axi_sram_if bus ();

   ysyx_23060240_axi_sram #(
      .DEPTH_LOG2(12),
      .RD_LAT    (RD_LAT),
      .BASE      (BASE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic bit m_in(input logic [31:0] a);
      longint la;
      la = longint'(a);
      return la >= longint'(BASE) && la < longint'(BASE) + 4 * WORDS;
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((longint'(a) - longint'(BASE)) / 4);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, input int stall,
                     input string tag);
      logic [31:0] ed;
      logic [1:0]  er;
      int n;
      if (m_in(a)) begin
         er = 2'b00;
         ed = mdl.exists(m_idx(a)) ? mdl[m_idx(a)] : 32'hx;
      end else begin
         er = 2'b10;
         ed = 32'd0;
      end
      n = 0;
      while (!bus.arready && n < 50) begin
         tick();
         n++;
      end
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      @(posedge clk);
      #1;
      bus.arvalid = 1'b0;
      n = 1;
      while (!bus.rvalid && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, n, RD_LAT);
      if (!$isunknown(ed)) chk({tag, "_rdata"}, bus.rdata, ed);
      chk({tag, "_rresp"}, 32'(bus.rresp), 32'(er));
      for (int i = 0; i < stall; i++) begin
         tick();
         chk({tag, "_hold_rvalid"}, 32'(bus.rvalid), 32'd1);
         if (!$isunknown(ed)) chk({tag, "_hold_rdata"}, bus.rdata, ed);
         chk({tag, "_hold_arready"}, 32'(bus.arready), 32'd0);
      end
      bus.rready = 1'b1;
      @(posedge clk);
      #1;
      bus.rready = 1'b0;
      chk({tag, "_post_arready"}, 32'(bus.arready), 32'd1);
      chk({tag, "_post_rvalid"}, 32'(bus.rvalid), 32'd0);
   endtask

   // mode 0: AW+W together; 1: W first; 2: AW first (gap cycles apart)
   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int mode, input int gap,
                     input int bstall, input string tag);
      int n;
      n = 0;
      while (!(bus.awready && bus.wready) && n < 50) begin
         tick();
         n++;
      end
      bus.awaddr = a;
      bus.wdata  = d;
      bus.wstrb  = s;
      if (mode == 0) begin
         bus.awvalid = 1'b1;
         bus.wvalid  = 1'b1;
         @(posedge clk);
         #1;
         bus.awvalid = 1'b0;
         bus.wvalid  = 1'b0;
      end else if (mode == 1) begin
         bus.wvalid = 1'b1;
         @(posedge clk);
         #1;
         bus.wvalid = 1'b0;
         chk({tag, "_wready_lo"}, 32'(bus.wready), 32'd0);
         chk({tag, "_awready_hi"}, 32'(bus.awready), 32'd1);
         repeat (gap - 1) tick();
         chk({tag, "_no_early_b"}, 32'(bus.bvalid), 32'd0);
         bus.awvalid = 1'b1;
         @(posedge clk);
         #1;
         bus.awvalid = 1'b0;
      end else begin
         bus.awvalid = 1'b1;
         @(posedge clk);
         #1;
         bus.awvalid = 1'b0;
         chk({tag, "_awready_lo"}, 32'(bus.awready), 32'd0);
         chk({tag, "_wready_hi"}, 32'(bus.wready), 32'd1);
         repeat (gap - 1) tick();
         chk({tag, "_no_early_b"}, 32'(bus.bvalid), 32'd0);
         bus.wvalid = 1'b1;
         @(posedge clk);
         #1;
         bus.wvalid = 1'b0;
      end
      if (m_in(a)) begin
         logic [31:0] w;
         w = mdl.exists(m_idx(a)) ? mdl[m_idx(a)] : 32'h0;
         for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
         if (mdl.exists(m_idx(a)) || s == 4'hF) mdl[m_idx(a)] = w;
      end
      chk({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
      chk({tag, "_bresp"}, 32'(bus.bresp), m_in(a) ? 32'd0 : 32'd2);
      for (int i = 0; i < bstall; i++) begin
         tick();
         chk({tag, "_hold_bvalid"}, 32'(bus.bvalid), 32'd1);
      end
      bus.bready = 1'b1;
      @(posedge clk);
      #1;
      bus.bready = 1'b0;
      chk({tag, "_post_bvalid"}, 32'(bus.bvalid), 32'd0);
      chk({tag, "_post_awready"}, 32'(bus.awready), 32'd1);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      bus.araddr  = '0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      bus.awaddr  = '0;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = '0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_arready", 32'(bus.arready), 32'd1);
      chk("rst_awready", 32'(bus.awready), 32'd1);
      chk("rst_wready", 32'(bus.wready), 32'd1);
      chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
      chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_rresp", 32'(bus.rresp), 32'd0);
      chk("rst_bresp", 32'(bus.bresp), 32'd0);

      wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, "w_same");
      rd(32'h8000_0010, 0, "r_beef");
      wr(32'h8000_0010, 32'h0000_CAFE, 4'b0011, 1, 2, 0, "w_wfirst");
      chk("model_cafe", mdl[4], 32'hDEAD_CAFE);
      rd(32'h8000_0010, 0, "r_cafe");
      rd(32'h8000_0012, 5, "r_stall");

      wr(32'h8000_0000, 32'h1234_5678, 4'hF, 2, 1, 1, "w_word0");
      rd(32'h7000_0000, 0, "r_oor_lo");
      rd(32'h8000_4000, 0, "r_oor_hi");
      wr(32'h7000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "w_oor");
      wr(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 1, 1, 0, "w_oor_hi");
      rd(32'h8000_0000, 0, "r_word0_kept");
      wr(32'h8000_0000, 32'hAAAA_AAAA, 4'h0, 0, 0, 0, "w_nostrb");
      rd(32'h8000_0000, 0, "r_nostrb");
      wr(32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 2, 2, 0, "w_last");
      rd(32'h8000_3FFF, 0, "r_last");

      bus.araddr  = 32'h8000_0010;
      bus.arvalid = 1'b1;
      @(posedge clk);
      #1;
      bus.arvalid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("ar_rst_arready", 32'(bus.arready), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("ar_rst_rvalid", 32'(bus.rvalid), 32'd0);
         tick();
      end

      bus.wdata  = 32'h5555_5555;
      bus.wstrb  = 4'hF;
      bus.wvalid = 1'b1;
      @(posedge clk);
      #1;
      bus.wvalid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst         = 1'b0;
      bus.awaddr  = 32'h8000_0010;
      bus.awvalid = 1'b1;
      @(posedge clk);
      #1;
      bus.awvalid = 1'b0;
      chk("w_rst_no_commit", 32'(bus.bvalid), 32'd0);
      chk("w_rst_wdata_st", 32'(bus.wready), 32'd1);
      bus.wdata  = 32'h0BAD_0BAD;
      bus.wstrb  = 4'h0;
      bus.wvalid = 1'b1;
      @(posedge clk);
      #1;
      bus.wvalid = 1'b0;
      chk("w_rst_bvalid", 32'(bus.bvalid), 32'd1);
      bus.bready = 1'b1;
      @(posedge clk);
      #1;
      bus.bready = 1'b0;
      rd(32'h8000_0010, 0, "r_after_wrst");

      for (int i = 0; i < 16; i++) begin
         addrs[i] = BASE + 32'(4 * ((i == 15) ? 4095 : 100 + i * 37));
         wr(addrs[i], $urandom, 4'hF, $urandom_range(0, 2),
            $urandom_range(1, 3), $urandom_range(0, 2), "rw_init");
      end
      for (int k = 0; k < 120; k++) begin
         logic [31:0] a;
         int sel;
         sel = $urandom_range(0, 15);
         a   = addrs[sel] | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
               0: a = 32'h7FFF_FFFC;
               1: a = 32'h8000_4000;
               default: a = 32'hFFFF_FFF0;
            endcase
         end
         if ($urandom_range(0, 1) == 0)
            wr(a, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 2), $urandom_range(1, 3),
               $urandom_range(0, 2), "rnd_wr");
         else
            rd(a, $urandom_range(0, 3), "rnd_rd");
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
